pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Owns the F-stage program counter and sequences instruction fetch against a ready-handshaked instruction memory.
- Consumes the 3-bit PC-select code produced by the D-stage branch comparator, plus exception-entry and eret requests from CP0.
- Computes the next PC and holds redirects that arrive while a fetch is still outstanding.
- Kills wrong-path fetches on exception or eret; preserves the MIPS branch delay slot.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded by reset
EXC_VECTOR, 32'h0000_4180, exception handler entry
IMEM_BASE, 32'h0000_3000, lowest legal fetch address
IMEM_LAST, 32'h0000_6FFC, highest legal fetch address

Ports:
clk  in  1  clock
reset  in  1  reset
stall  in  1  D-stage hold; freezes PC advance and blocks pc_sel
pc_sel  in  3  0 PC+4, 1 rel branch, 2 j/jal, 3 jr/jalr, 4 alt_target; 5-7 treated as 0
pc_d  in  32  PC of the D-stage instruction
imm16  in  16  branch offset of the D instruction
instr_index  in  26  j/jal index field
rs_val  in  32  forwarded rs for jr/jalr
alt_target  in  32  target for code 4
exc_req  in  1  exception entry
eret_req  in  1  return to epc
epc  in  32  CP0 EPC
imem_ready  in  1  fetch data valid this cycle
imem_req  out  1  fetch request for pc_f
pc_f  out  32  current fetch PC
instr_valid_f  out  1  F instruction delivered and not killed
adel_f  out  1  fetch address error for pc_f

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - pc_f = RESET_PC; state = IDLE.
  - imem_req = 0, instr_valid_f = 0, adel_f = 0.
  - pend_pc = 0, pend_kill = 0.
- Target arithmetic, all mod 2^32:
  - code 1: pc_d + 4 + (sign-extended imm16 << 2).
  - code 2: {(pc_d+4)[31:28], instr_index, 2'b00}.
  - code 3: rs_val. code 4: alt_target.
  - code 0: pc_f + 4.
- Event priority per cycle: exc_req > eret_req > stall > pc_sel.
  - exc/eret act even when stall = 1.
  - pc_sel is sampled only when stall = 0.
- adel_f is combinational from pc_f: 1 if pc_f[1:0] != 0 or pc_f lies outside [IMEM_BASE, IMEM_LAST].
- FSM:
  - IDLE: one cycle after reset, imem_req = 0, then go to FETCH.
  - FETCH, imem_req = !adel_f:
    - Delivery occurs on imem_ready = 1, or immediately if adel_f = 1 (no memory access); instr_valid_f = 1 that cycle.
    - On delivery, pc_f advances to the selected target; if stall = 1, pc_f holds and the same PC is refetched.
    - exc/eret on the delivery cycle: instr_valid_f = 0 (kill); pc_f <= EXC_VECTOR or epc.
    - Redirect while not delivered (imem_ready = 0, adel_f = 0): pend_pc <= target; go to PEND.
      - Set pend_kill = 1 for exc/eret.
      - pend_kill = 0 for pc_sel != 0, because the in-flight word is the delay slot.
  - PEND, imem_req = 1, pc_f held stable:
    - On imem_ready: instr_valid_f = !pend_kill; pc_f <= pend_pc; clear pend_kill; go to FETCH.
    - exc/eret during PEND overwrite pend_pc and set pend_kill (exc beats eret).
    - pc_sel is ignored in PEND.
- imem handshake: pc_f must not change while imem_req = 1 and imem_ready = 0.
- Reset mid-fetch or in PEND: pending target discarded; state returns to IDLE.
- PC+4 wrap past 32'hFFFF_FFFC wraps to 0 and raises adel_f.

Optional Feature:
- Macro: PCSEQ_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_redirect_cnt[31:0]: counts accepted pc_sel != 0 redirects.
  - perf_kill_cnt[15:0]: counts killed fetches.
- Both counters saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pcseq_pkg holds:
  - PCSEL_* code constants (NPC, BR, J, JR, ALT).
  - Typedef for the IDLE/FETCH/PEND state.
  - Default address constants.
- One sub-module, npc_calc: combinational target selection and arithmetic (pc_sel, pc_d, imm16, instr_index, rs_val, alt_target, pc_f -> next_pc).

Test Plan:
- Reset, imem_ready tied 1 -> pc_f 0x3000, 0x3004, 0x3008 on consecutive deliveries; instr_valid_f first high in the 2nd cycle after reset release.
- pc_sel=1, pc_d=0x3010, imm16=0xFFFE, ready=1 -> next pc_f = 0x300C; current F word stays valid as the delay slot.
- pc_sel=3, rs_val=0x3400 with imem_ready=0 for 3 cycles -> state PEND, pc_f held; on ready, instr_valid_f=1 and pc_f becomes 0x3400.
- exc_req with stall=1 and ready=0 for 2 cycles -> on ready, instr_valid_f=0 and pc_f becomes 0x4180.
- eret_req with epc=0x3002 -> pc_f=0x3002, adel_f=1, imem_req=0, instr_valid_f=1 without waiting for ready.
- exc_req and eret_req in the same cycle -> pc_f = 0x4180; with PCSEQ_PERF_CNT_EN, perf_kill_cnt increments by 1.

Source files
------------

// File: rtl/pcseq_pkg.sv
// Shared constants and types for the F-stage PC sequencer: pc_sel codes,
// FSM state encoding and default address map.
package pcseq_pkg;

    localparam logic [2:0] PCSEL_NPC = 3'd0;
    localparam logic [2:0] PCSEL_BR  = 3'd1;
    localparam logic [2:0] PCSEL_J   = 3'd2;
    localparam logic [2:0] PCSEL_JR  = 3'd3;
    localparam logic [2:0] PCSEL_ALT = 3'd4;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_LAST  = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PEND  = 2'd2
    } pcseq_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_npc_calc.sv
// Next-PC target selection for the fetch sequencer; purely combinational.
// Codes 5-7 fall back to sequential PC+4 and are not reported as redirects.
module npc_calc
    import pcseq_pkg::*;
(
    input  logic [2:0]  pc_sel_i,
    input  logic [31:0] pc_d_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] alt_target_i,
    input  logic [31:0] pc_f_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o
);

    logic [31:0] pc_d_plus4;
    logic [31:0] br_off;

    assign pc_d_plus4 = pc_d_i + 32'd4;
    assign br_off     = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        next_pc_o  = pc_f_i + 32'd4;
        redirect_o = 1'b1;
        case (pc_sel_i)
            PCSEL_BR:  next_pc_o = pc_d_plus4 + br_off;
            PCSEL_J:   next_pc_o = {pc_d_plus4[31:28], instr_index_i, 2'b00};
            PCSEL_JR:  next_pc_o = rs_val_i;
            PCSEL_ALT: next_pc_o = alt_target_i;
            default:   redirect_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// F-stage PC owner: sequences fetches against a ready-handshaked imem, parks
// redirects that arrive mid-fetch and kills wrong-path words on exc/eret.
// Optional PCSEQ_PERF_CNT_EN adds saturating redirect/kill counters.
module pc_fetch_sequencer
    import pcseq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter logic [31:0] IMEM_LAST  = DEF_IMEM_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic [31:0] alt_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc_f,
    output logic        instr_valid_f,
    output logic        adel_f
`ifdef PCSEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_redirect_cnt,
    output logic [15:0] perf_kill_cnt
`endif
);

    pcseq_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_kill_q, pend_kill_d;

    logic [31:0]  npc;
    logic         npc_redirect;
    logic         deliver;
    logic         redir_evt;
    logic [31:0]  redir_pc;
    logic         redir_acc;
    logic         kill_evt;

    npc_calc u_npc_calc (
        .pc_sel_i      (pc_sel),
        .pc_d_i        (pc_d),
        .imm16_i       (imm16),
        .instr_index_i (instr_index),
        .rs_val_i      (rs_val),
        .alt_target_i  (alt_target),
        .pc_f_i        (fetch_pc_q),
        .next_pc_o     (npc),
        .redirect_o    (npc_redirect)
    );

    assign pc_f   = fetch_pc_q;
    assign adel_f = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < IMEM_BASE) ||
                    (fetch_pc_q > IMEM_LAST);

    // A faulting address never touches memory, so it "delivers" at once.
    assign deliver   = imem_ready || adel_f;
    assign redir_evt = exc_req || eret_req;
    assign redir_pc  = exc_req ? EXC_VECTOR : epc;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_pc_d     = pend_pc_q;
        pend_kill_d   = pend_kill_q;
        imem_req      = 1'b0;
        instr_valid_f = 1'b0;
        redir_acc     = 1'b0;
        kill_evt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = !adel_f;
                if (redir_evt) begin
                    if (deliver) begin
                        kill_evt   = 1'b1;
                        fetch_pc_d = redir_pc;
                    end else begin
                        pend_pc_d   = redir_pc;
                        pend_kill_d = 1'b1;
                        state_d     = ST_PEND;
                    end
                end else begin
                    instr_valid_f = deliver;
                    if (!stall) begin
                        redir_acc = npc_redirect;
                        if (deliver) begin
                            fetch_pc_d = npc;
                        end else if (npc_redirect) begin
                            // In-flight word is the delay slot: keep it.
                            pend_pc_d   = npc;
                            pend_kill_d = 1'b0;
                            state_d     = ST_PEND;
                        end
                    end
                end
            end
            ST_PEND: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d     = ST_FETCH;
                    pend_kill_d = 1'b0;
                    if (redir_evt) begin
                        kill_evt   = 1'b1;
                        fetch_pc_d = redir_pc;
                    end else begin
                        instr_valid_f = !pend_kill_q;
                        kill_evt      = pend_kill_q;
                        fetch_pc_d    = pend_pc_q;
                    end
                end else if (redir_evt) begin
                    pend_pc_d   = redir_pc;
                    pend_kill_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            pend_pc_q   <= '0;
            pend_kill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pend_pc_q   <= pend_pc_d;
            pend_kill_q <= pend_kill_d;
        end
    end

`ifdef PCSEQ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    logic [31:0] redir_cnt_q;
    logic [15:0] kill_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            redir_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (redir_acc) redir_cnt_q <= sat_inc32(redir_cnt_q);
            if (kill_evt)  kill_cnt_q  <= sat_inc16(kill_cnt_q);
        end
    end

    assign perf_redirect_cnt = redir_cnt_q;
    assign perf_kill_cnt     = kill_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = ^{redir_acc, kill_evt};
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: inputs change on the falling edge,
// outputs are sampled mid-cycle; expected values are hand-computed constants.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_sel;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic [31:0] alt_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc_f;
    logic        instr_valid_f;
    logic        adel_f;
`ifdef PCSEQ_PERF_CNT_EN
    logic [31:0] perf_redirect_cnt;
    logic [15:0] perf_kill_cnt;
    logic [15:0] kill_base;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_sel        (pc_sel),
        .pc_d          (pc_d),
        .imm16         (imm16),
        .instr_index   (instr_index),
        .rs_val        (rs_val),
        .alt_target    (alt_target),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc_f          (pc_f),
        .instr_valid_f (instr_valid_f),
        .adel_f        (adel_f)
`ifdef PCSEQ_PERF_CNT_EN
        ,
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_kill_cnt     (perf_kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: across the rising edge, back to the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc_sel = 3'd0; pc_d = '0; imm16 = '0;
        instr_index = '0; rs_val = '0; alt_target = '0; exc_req = 1'b0;
        eret_req = 1'b0; epc = '0; imem_ready = 1'b0;
        step(); step();
        check("rst_pc", pc_f, 32'h0000_3000);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid_f, 0);
        check("rst_adel", adel_f, 0);
`ifdef PCSEQ_PERF_CNT_EN
        check("rst_redir_cnt", perf_redirect_cnt, 0);
        check("rst_kill_cnt", perf_kill_cnt, 0);
`endif

        // Sequential fetch with memory always ready
        reset = 1'b0; imem_ready = 1'b1; #1;
        check("idle_req", imem_req, 0);
        check("idle_valid", instr_valid_f, 0);
        step();
        check("seq0_pc", pc_f, 32'h0000_3000);
        check("seq0_valid", instr_valid_f, 1);
        check("seq0_req", imem_req, 1);
        step();
        check("seq1_pc", pc_f, 32'h0000_3004);
        check("seq1_valid", instr_valid_f, 1);
        step();
        check("seq2_pc", pc_f, 32'h0000_3008);

        // Backward relative branch; current F word is the delay slot
        pc_sel = 3'd1; pc_d = 32'h0000_3010; imm16 = 16'hFFFE; #1;
        check("br_slot_valid", instr_valid_f, 1);
        step(); pc_sel = 3'd0;
        check("br_pc", pc_f, 32'h0000_300C);

        // jr while memory is busy: parked in PEND, delay slot kept
        pc_sel = 3'd3; rs_val = 32'h0000_3400; imem_ready = 1'b0; #1;
        check("jr_wait_valid", instr_valid_f, 0);
        check("jr_wait_req", imem_req, 1);
        step(); pc_sel = 3'd0; #1;
        check("pend1_pc", pc_f, 32'h0000_300C);
        check("pend1_req", imem_req, 1);
        check("pend1_valid", instr_valid_f, 0);
        step();
        check("pend2_pc", pc_f, 32'h0000_300C);
        imem_ready = 1'b1; #1;
        check("pend_done_valid", instr_valid_f, 1);
        check("pend_done_pc", pc_f, 32'h0000_300C);
        step();
        check("jr_pc", pc_f, 32'h0000_3400);

        // Exception under stall while memory busy: killed word, vector on ready
        stall = 1'b1; exc_req = 1'b1; imem_ready = 1'b0; #1;
        check("exc_wait_valid", instr_valid_f, 0);
        check("exc_wait_req", imem_req, 1);
        step();
        check("exc_pend_pc", pc_f, 32'h0000_3400);
        check("exc_pend_req", imem_req, 1);
        step();
        exc_req = 1'b0; stall = 1'b0; imem_ready = 1'b1; #1;
        check("exc_kill_valid", instr_valid_f, 0);
        step();
        check("exc_pc", pc_f, 32'h0000_4180);
        check("exc_adel", adel_f, 0);

        // eret to a misaligned epc: no memory access, delivers immediately
        eret_req = 1'b1; epc = 32'h0000_3002; #1;
        check("eret_kill_valid", instr_valid_f, 0);
        step();
        eret_req = 1'b0; imem_ready = 1'b0; #1;
        check("eret_pc", pc_f, 32'h0000_3002);
        check("eret_adel", adel_f, 1);
        check("eret_req_low", imem_req, 0);
        check("eret_valid", instr_valid_f, 1);
        step();
        check("adel_seq_pc", pc_f, 32'h0000_3006);

        // exc and eret together: exception wins
`ifdef PCSEQ_PERF_CNT_EN
        kill_base = perf_kill_cnt;
`endif
        exc_req = 1'b1; eret_req = 1'b1; imem_ready = 1'b1; #1;
        check("both_valid", instr_valid_f, 0);
        step();
        exc_req = 1'b0; eret_req = 1'b0;
        check("both_pc", pc_f, 32'h0000_4180);
`ifdef PCSEQ_PERF_CNT_EN
        check("both_kill_inc", perf_kill_cnt, kill_base + 16'd1);
`endif

        // Upper edge of the legal window
        pc_sel = 3'd3; rs_val = 32'h0000_6FFC;
        step(); pc_sel = 3'd0;
        check("last_pc", pc_f, 32'h0000_6FFC);
        check("last_adel", adel_f, 0);
        check("last_req", imem_req, 1);
        step();
        check("past_pc", pc_f, 32'h0000_7000);
        check("past_adel", adel_f, 1);
        check("past_req", imem_req, 0);

        // PC+4 wrap at the top of the address space
        pc_sel = 3'd3; rs_val = 32'hFFFF_FFFC;
        step(); pc_sel = 3'd0;
        check("top_pc", pc_f, 32'hFFFF_FFFC);
        check("top_adel", adel_f, 1);
        step();
        check("wrap_pc", pc_f, 32'h0000_0000);
        check("wrap_adel", adel_f, 1);

        // j keeps the upper nibble of pc_d+4
        pc_sel = 3'd2; pc_d = 32'h1FFF_FFFC; instr_index = 26'h000_0C00;
        step();
        check("j_pc", pc_f, 32'h2000_3000);

        // alt_target
        pc_sel = 3'd4; alt_target = 32'h0000_5000;
        step(); pc_sel = 3'd0;
        check("alt_pc", pc_f, 32'h0000_5000);
        check("alt_adel", adel_f, 0);

        // stall blocks pc_sel and refetches the same PC
        stall = 1'b1; pc_sel = 3'd1; pc_d = 32'h0000_3010; imm16 = 16'hFFFE; #1;
        check("stall_valid", instr_valid_f, 1);
        step();
        check("stall_pc", pc_f, 32'h0000_5000);

        // Reserved code behaves as PC+4
        stall = 1'b0; pc_sel = 3'd5;
        step(); pc_sel = 3'd0;
        check("code5_pc", pc_f, 32'h0000_5004);
`ifdef PCSEQ_PERF_CNT_EN
        check("redir_cnt", perf_redirect_cnt, 32'd6);
`endif

        // Reset while a redirect is parked discards it
        pc_sel = 3'd3; rs_val = 32'h0000_3800; imem_ready = 1'b0;
        step();
        pc_sel = 3'd0; reset = 1'b1;
        step();
        check("rst2_pc", pc_f, 32'h0000_3000);
        check("rst2_req", imem_req, 0);
`ifdef PCSEQ_PERF_CNT_EN
        check("rst2_redir_cnt", perf_redirect_cnt, 0);
`endif
        reset = 1'b0; imem_ready = 1'b1;
        step();
        check("rst2_fetch_pc", pc_f, 32'h0000_3000);
        check("rst2_fetch_valid", instr_valid_f, 1);
        step();
        check("rst2_next_pc", pc_f, 32'h0000_3004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
